// File: rtl/ldpc_descramble_pack_pkg.sv
// Shared constants for the LDPC output descrambler/packer and the matching
// transmit-side scrambler: frame geometry, PRBS15 seed/taps, counter widths.
package ldpc_descramble_pack_pkg;

    localparam int unsigned LDPC_FRAME_BITS  = 4320;
    localparam int unsigned LDPC_FRAME_BYTES = LDPC_FRAME_BITS / 8;

    localparam int unsigned PRBS_W      = 15;
    localparam int unsigned PRBS_TAP_HI = 14;
    localparam int unsigned PRBS_TAP_LO = 13;
    localparam logic [PRBS_W-1:0] LDPC_PRBS_SEED = 15'b100101010000000;

    localparam int unsigned BIT_CNT_W  = 13;
    localparam int unsigned BYTE_CNT_W = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // x^15 + x^14 + 1 feedback, also the scrambling bit for the current state
    function automatic logic prbs_feedback(input logic [PRBS_W-1:0] r);
        return r[PRBS_TAP_HI] ^ r[PRBS_TAP_LO];
    endfunction

endpackage

// File: rtl/ldpc_descramble_pack_prbs15_gen.sv
// PRBS15 generator: bit_o is the scrambling bit of the current state; advance
// shifts it in, load restores the seed (load wins over advance).
module prbs15_gen
    import ldpc_descramble_pack_pkg::*;
#(
    parameter logic [PRBS_W-1:0] SEED = LDPC_PRBS_SEED
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic advance_i,
    output logic bit_o
);

    logic [PRBS_W-1:0] lfsr_q, lfsr_d;

    assign bit_o = prbs_feedback(lfsr_q);

    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = SEED;
        end else if (advance_i) begin
            lfsr_d = {lfsr_q[PRBS_W-2:0], bit_o};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/ldpc_descramble_pack.sv
// Captures a decoded LDPC frame bit-serially after frame_finish, removes the
// PRBS15 scrambling and emits MSB-first bytes with sop/eop markers.
module ldpc_descramble_pack
    import ldpc_descramble_pack_pkg::*;
#(
    parameter int unsigned       FRAME_BITS = LDPC_FRAME_BITS,
    parameter logic [PRBS_W-1:0] PRBS_SEED  = LDPC_PRBS_SEED,
    parameter bit                DESCR_EN   = 1'b1
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       ldpc_dout,
    input  logic       frame_finish,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       byte_sop,
    output logic       byte_eop,
    output logic       frame_done,
    output logic       overrun_err
);

    localparam int unsigned FRAME_BYTES = FRAME_BITS / 8;

    state_t                state_q, state_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [6:0]            shift_q, shift_d;
    logic [7:0]            byte_q, byte_d;
    logic                  valid_q, valid_d;
    logic                  sop_q, sop_d;
    logic                  eop_q, eop_d;
    logic                  overrun_q, overrun_d;

    logic prbs_bit;
    logic prbs_load;
    logic prbs_adv;
    logic sample;
    logic data_bit;
    logic byte_end;

    prbs15_gen #(
        .SEED (PRBS_SEED)
    ) u_prbs (
        .clk_i     (clk_in),
        .rst_ni    (reset),
        .load_i    (prbs_load),
        .advance_i (prbs_adv),
        .bit_o     (prbs_bit)
    );

    assign data_bit = ldpc_dout ^ (DESCR_EN ? prbs_bit : 1'b0);

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        byte_d     = byte_q;
        valid_d    = 1'b0;
        sop_d      = 1'b0;
        eop_d      = 1'b0;
        overrun_d  = overrun_q;
        sample     = 1'b0;
        prbs_load  = 1'b0;
        prbs_adv   = 1'b0;
        byte_end   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (frame_finish) begin
                    sample     = 1'b1;
                    prbs_adv   = 1'b1;
                    bit_cnt_d  = BIT_CNT_W'(1);
                    byte_cnt_d = '0;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                sample   = 1'b1;
                byte_end = (bit_cnt_q[2:0] == 3'd7);
                if (frame_finish) begin
                    overrun_d = 1'b1;
                end
                if (bit_cnt_q == BIT_CNT_W'(FRAME_BITS - 1)) begin
                    prbs_load = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    prbs_adv  = 1'b1;
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Byte boundaries only fall in RUN since bit 0 is always taken from IDLE
        if (sample) begin
            shift_d = {shift_q[5:0], data_bit};
            if (byte_end) begin
                byte_d  = {shift_q, data_bit};
                valid_d = 1'b1;
                sop_d   = (byte_cnt_q == '0);
                eop_d   = (byte_cnt_q == BYTE_CNT_W'(FRAME_BYTES - 1));
                byte_cnt_d = eop_d ? '0 : byte_cnt_q + BYTE_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            byte_q     <= '0;
            valid_q    <= 1'b0;
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            byte_q     <= byte_d;
            valid_q    <= valid_d;
            sop_q      <= sop_d;
            eop_q      <= eop_d;
            overrun_q  <= overrun_d;
        end
    end

    assign byte_out    = byte_q;
    assign byte_valid  = valid_q;
    assign byte_sop    = sop_q;
    assign byte_eop    = eop_q;
    assign frame_done  = eop_q;
    assign overrun_err = overrun_q;

endmodule

// File: tb/tb_ldpc_descramble_pack.sv
// Bench for ldpc_descramble_pack: one bypass and one descrambling instance fed
// the same bit stream, checked against a byte-level scoreboard every cycle.
module tb_ldpc_descramble_pack;
    import ldpc_descramble_pack_pkg::*;

    localparam int FB = 4320;
    localparam int NB = FB / 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic din = 1'b0;
    logic ff = 1'b0;

    logic [7:0] bo [2];
    logic       bv [2];
    logic       bs [2];
    logic       be [2];
    logic       fd [2];
    logic       ov [2];

    ldpc_descramble_pack #(
        .FRAME_BITS (FB),
        .PRBS_SEED  (15'b100101010000000),
        .DESCR_EN   (1'b0)
    ) dut_raw (
        .clk_in       (clk),
        .reset        (rst_n),
        .ldpc_dout    (din),
        .frame_finish (ff),
        .byte_out     (bo[0]),
        .byte_valid   (bv[0]),
        .byte_sop     (bs[0]),
        .byte_eop     (be[0]),
        .frame_done   (fd[0]),
        .overrun_err  (ov[0])
    );

    ldpc_descramble_pack #(
        .FRAME_BITS (FB),
        .PRBS_SEED  (15'b100101010000000),
        .DESCR_EN   (1'b1)
    ) dut_scr (
        .clk_in       (clk),
        .reset        (rst_n),
        .ldpc_dout    (din),
        .frame_finish (ff),
        .byte_out     (bo[1]),
        .byte_valid   (bv[1]),
        .byte_sop     (bs[1]),
        .byte_eop     (be[1]),
        .frame_done   (fd[1]),
        .overrun_err  (ov[1])
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        bit         sop;
        bit         eop;
        longint     due;
    } exp_t;

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    longint ovr_edge = -1;
    bit     mon_en = 1'b0;

    exp_t       q [2][$];
    bit         frm [FB];
    bit         pr [FB];
    int         nbytes [2];
    int         nsop [2];
    int         neop [2];
    logic [7:0] heads [2][$];
    longint     start_edge;
    longint     first_valid;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // PRBS as a sequence: x[0..14] are the seed bits from bit 14 down, each
    // later term is x[n-15]^x[n-14], and the k-th scrambling bit is x[k+15].
    function automatic void build_prbs(input logic [14:0] seed);
        bit x [FB + 15];
        for (int i = 0; i < 15; i++) x[i] = seed[14 - i];
        for (int n = 15; n < FB + 15; n++) x[n] = x[n - 15] ^ x[n - 14];
        for (int k = 0; k < FB; k++) pr[k] = x[k + 15];
    endfunction

    function automatic logic [7:0] raw_byte(input int n);
        logic [7:0] b;
        for (int j = 0; j < 8; j++) b[7 - j] = frm[8 * n + j];
        return b;
    endfunction

    function automatic logic [7:0] prbs_byte(input int n);
        logic [7:0] b;
        for (int j = 0; j < 8; j++) b[7 - j] = pr[8 * n + j];
        return b;
    endfunction

    task automatic chk_dut(input int k);
        string nm;
        exp_t  e;
        logic  ov_exp;
        nm = (k == 0) ? "raw" : "scr";
        if (bv[k]) begin
            if (q[k].size() == 0 || q[k][0].due != cyc) begin
                checks++;
                errors++;
                $display("FAIL %s_unexpected_valid: got byte %0h expected no strobe (cycle %0d)", nm, bo[k], cyc);
            end else begin
                e = q[k].pop_front();
                chk({nm, "_byte"}, 32'(bo[k]), 32'(e.d));
                chk({nm, "_sop"}, 32'(bs[k]), 32'(e.sop));
                chk({nm, "_eop"}, 32'(be[k]), 32'(e.eop));
                chk({nm, "_frame_done"}, 32'(fd[k]), 32'(e.eop));
                if (bs[k]) begin
                    nbytes[k] = 0;
                    nsop[k]++;
                    if (k == 0) first_valid = cyc;
                end
                if (nbytes[k] < 2) heads[k].push_back(bo[k]);
                nbytes[k]++;
                if (be[k]) neop[k]++;
            end
        end else begin
            if (q[k].size() > 0 && q[k][0].due == cyc) begin
                e = q[k].pop_front();
                checks++;
                errors++;
                $display("FAIL %s_missing_valid: got no strobe expected byte %0h (cycle %0d)", nm, e.d, cyc);
            end
            chk({nm, "_idle_strobes"}, 32'({bs[k], be[k], fd[k]}), 32'(0));
        end
        ov_exp = (ovr_edge >= 0) && (cyc >= ovr_edge);
        chk({nm, "_overrun"}, 32'(ov[k]), 32'(ov_exp));
    endtask

    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            chk_dut(0);
            chk_dut(1);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            ff  = 1'b0;
            din = 1'b0;
        end
    endtask

    task automatic reset_dut(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        ff = 1'b0;
        din = 1'b0;
        ovr_edge = -1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("reset_outputs", 32'({bo[k], bv[k], bs[k], be[k], fd[k], ov[k]}), 32'(0));
        end
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drives frm[] bit per cycle; ovr_at re-pulses frame_finish, abort_at pulls reset
    task automatic drive_frame(input int ovr_at, input int abort_at);
        exp_t e;
        for (int i = 0; i < FB; i++) begin
            @(negedge clk);
            if (i == abort_at) begin
                rst_n = 1'b0;
                ff = 1'b0;
                din = 1'b0;
                ovr_edge = -1;
                return;
            end
            din = frm[i];
            ff  = (i == 0) || (i == ovr_at);
            if (i == 0) start_edge = cyc + 1;
            if (i == ovr_at && ovr_edge < 0) ovr_edge = cyc + 1;
            if (i % 8 == 7) begin
                e.sop = (i == 7);
                e.eop = (i == FB - 1);
                e.due = cyc + 1;
                e.d = raw_byte(i / 8);
                q[0].push_back(e);
                e.d = raw_byte(i / 8) ^ prbs_byte(i / 8);
                q[1].push_back(e);
            end
        end
    endtask

    task automatic clear_counts();
        for (int k = 0; k < 2; k++) begin
            nsop[k] = 0;
            neop[k] = 0;
            heads[k].delete();
        end
    endtask

    initial begin
        build_prbs(15'b100101010000000);
        chk("model_prbs_byte0", 32'(prbs_byte(0)), 32'h0000_00BF);
        chk("model_prbs_byte1", 32'(prbs_byte(1)), 32'h0000_0003);

        #2;
        reset_dut(3);
        mon_en = 1'b1;
        idle(3);

        // All ones, bypass path must give 0xFF bytes
        clear_counts();
        for (int i = 0; i < FB; i++) frm[i] = 1'b1;
        drive_frame(-1, -1);
        idle(12);
        chk("ones_nbytes", 32'(nbytes[0]), 32'(NB));
        chk("ones_sop_count", 32'(nsop[0]), 32'(1));
        chk("ones_eop_count", 32'(neop[0]), 32'(1));
        chk("ones_first_byte", 32'(heads[0][0]), 32'h0000_00FF);
        chk("first_valid_latency", 32'(first_valid - start_edge), 32'(7));

        // Alternating 1,0 checks MSB-first order
        clear_counts();
        for (int i = 0; i < FB; i++) frm[i] = (i % 2 == 0);
        drive_frame(-1, -1);
        idle(12);
        chk("alt_first_byte", 32'(heads[0][0]), 32'h0000_00AA);
        chk("alt_nbytes", 32'(nbytes[0]), 32'(NB));

        // All zeros twice back-to-back: PRBS sequence restarts from the seed
        clear_counts();
        for (int i = 0; i < FB; i++) frm[i] = 1'b0;
        drive_frame(-1, -1);
        drive_frame(-1, -1);
        idle(12);
        chk("zero_heads_count", 32'(heads[1].size()), 32'(4));
        if (heads[1].size() == 4) begin
            chk("zero_f0_b0", 32'(heads[1][0]), 32'h0000_00BF);
            chk("zero_f0_b1", 32'(heads[1][1]), 32'h0000_0003);
            chk("zero_f1_b0", 32'(heads[1][2]), 32'h0000_00BF);
            chk("zero_f1_b1", 32'(heads[1][3]), 32'h0000_0003);
        end
        chk("zero_eop_count", 32'(neop[1]), 32'(2));

        // Scrambled random payload, two frames back-to-back
        clear_counts();
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < FB; i++) frm[i] = 1'($urandom_range(0, 1)) ^ pr[i];
            drive_frame(-1, -1);
        end
        idle(12);
        chk("payload_sop_count", 32'(nsop[1]), 32'(2));
        chk("payload_eop_count", 32'(neop[1]), 32'(2));

        // Overrun: frame_finish re-pulsed at bit 2000
        clear_counts();
        for (int i = 0; i < FB; i++) frm[i] = 1'($urandom_range(0, 1));
        drive_frame(2000, -1);
        idle(20);
        chk("overrun_raw_sticky", 32'(ov[0]), 32'(1));
        chk("overrun_scr_sticky", 32'(ov[1]), 32'(1));
        chk("overrun_frame_eop", 32'(neop[0]), 32'(1));
        chk("overrun_nbytes", 32'(nbytes[0]), 32'(NB));
        reset_dut(2);
        idle(2);
        chk("overrun_cleared", 32'(ov[0] | ov[1]), 32'(0));

        // Reset mid-frame at bit 1000, then a clean frame
        clear_counts();
        for (int i = 0; i < FB; i++) frm[i] = 1'($urandom_range(0, 1));
        drive_frame(-1, 1000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(4);
        chk("abort_nbytes", 32'(nbytes[0]), 32'(125));
        chk("abort_no_eop", 32'(neop[0] + neop[1]), 32'(0));
        clear_counts();
        for (int i = 0; i < FB; i++) frm[i] = 1'($urandom_range(0, 1)) ^ pr[i];
        drive_frame(-1, -1);
        idle(12);
        chk("after_abort_sop", 32'(nsop[1]), 32'(1));
        chk("after_abort_eop", 32'(neop[1]), 32'(1));
        chk("after_abort_nbytes", 32'(nbytes[1]), 32'(NB));

        chk("raw_queue_drained", 32'(q[0].size()), 32'(0));
        chk("scr_queue_drained", 32'(q[1].size()), 32'(0));

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
